// File: rtl/gprf_wb_arbiter.sv
// Round-robin arbiter for the shared GPR write port, with a registered write drive
// and a per-register busy scoreboard that feeds the issue-stage hazard check.
module gprf_wb_arbiter #(
   parameter int unsigned NREQ     = 3,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned RCNT_LOG = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*RCNT_LOG-1:0]     req_rd_addr,
   input  logic [NREQ*XLEN-1:0]         req_data,
   output logic [NREQ-1:0]              req_ready,
   input  logic                         rsv_valid,
   input  logic [RCNT_LOG-1:0]          rsv_addr,
   input  logic [RCNT_LOG-1:0]          chk_rs1_addr,
   input  logic [RCNT_LOG-1:0]          chk_rs2_addr,
   input  logic [RCNT_LOG-1:0]          chk_rd_addr,
   output logic                         chk_busy,
   output logic [(2**RCNT_LOG)-1:0]     busy_mask,
   output logic                         wr_enable,
   output logic [RCNT_LOG-1:0]          rd_addr,
   output logic [XLEN-1:0]              rd,
   output logic                         sb_err
);

   localparam int unsigned RCNT  = 2**RCNT_LOG;
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    ptr_next;
   logic [PTR_W-1:0]    gnt_idx;
   logic [PTR_W:0]      scan;
   logic                gnt_any;
   logic [RCNT_LOG-1:0] gnt_addr;
   logic [XLEN-1:0]     gnt_data;
   logic                clr_hit;
   logic                unrsv_err;
   logic                waw_err;
   logic [RCNT-1:0]     busy_next;

   logic [RCNT_LOG-1:0] addr_arr [NREQ];
   logic [XLEN-1:0]     data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_arr[i] = req_rd_addr[i*RCNT_LOG +: RCNT_LOG];
      assign data_arr[i] = req_data[i*XLEN +: XLEN];
   end

   // Scan from the pointer; the first valid requester wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan = {1'b0, ptr} + (PTR_W+1)'(k);
         if (scan >= (PTR_W+1)'(NREQ)) begin
            scan = scan - (PTR_W+1)'(NREQ);
         end
         if (!gnt_any && req_valid[scan[PTR_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[PTR_W-1:0];
         end
      end
      if (rst) begin
         gnt_any = 1'b0;
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_any) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign ptr_next = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
   assign gnt_addr = addr_arr[gnt_idx];
   assign gnt_data = data_arr[gnt_idx];

   // A committing write releases its register on the same edge the file takes the data.
   assign clr_hit   = wr_enable && (rd_addr != '0);
   assign unrsv_err = gnt_any && (gnt_addr != '0) && !busy_mask[gnt_addr] &&
                      !(rsv_valid && (rsv_addr == gnt_addr));
   assign waw_err   = rsv_valid && (rsv_addr != '0) && busy_mask[rsv_addr] &&
                      !(clr_hit && (rd_addr == rsv_addr));

   // Set is applied after clear so a same-edge re-reservation stays outstanding.
   always_comb begin
      busy_next = busy_mask;
      if (clr_hit) begin
         busy_next[rd_addr] = 1'b0;
      end
      if (rsv_valid) begin
         busy_next[rsv_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   assign chk_busy = busy_mask[chk_rs1_addr] | busy_mask[chk_rs2_addr] | busy_mask[chk_rd_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         wr_enable <= 1'b0;
         rd_addr   <= '0;
         rd        <= '0;
         busy_mask <= '0;
         sb_err    <= 1'b0;
      end else begin
         busy_mask <= busy_next;
         if (unrsv_err || waw_err) begin
            sb_err <= 1'b1;
         end
         if (gnt_any) begin
            ptr       <= ptr_next;
            wr_enable <= (gnt_addr != '0);
            rd_addr   <= gnt_addr;
            rd        <= gnt_data;
         end else begin
            wr_enable <= 1'b0;
         end
      end
   end

endmodule

// File: doc/gprf_wb_arbiter.md
Name: gprf_wb_arbiter

Overview:
- Shares the single write port of the general-purpose register file among NREQ writeback requesters (ALU, LSU, MULDIV).
- Uses round-robin arbitration with a valid/ready handshake and a registered write-port drive.
- Holds a per-register busy scoreboard. Issue reserves a destination register; the committed write releases it.
- Sits between the execute units and the register file write port. Also feeds the issue-stage hazard check.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, isa::XLEN, data width
RCNT_LOG, isa::RCNT_LOG, register address width; RCNT = 2**RCNT_LOG

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  writeback request per requester
req_rd_addr  in  NREQ*RCNT_LOG  destination address; requester i uses slice i
req_data  in  NREQ*XLEN  writeback data; requester i uses slice i
req_ready  out  NREQ  one-hot grant; transfer when valid&ready
rsv_valid  in  1  issue stage reserves rsv_addr this cycle
rsv_addr  in  RCNT_LOG  register being reserved
chk_rs1_addr  in  RCNT_LOG  hazard-check source 1
chk_rs2_addr  in  RCNT_LOG  hazard-check source 2
chk_rd_addr  in  RCNT_LOG  hazard-check destination (WAW)
chk_busy  out  1  any checked register busy
busy_mask  out  RCNT  scoreboard state; bit 0 is always 0
wr_enable  out  1  register file write enable (registered)
rd_addr  out  RCNT_LOG  register file write address (registered)
rd  out  XLEN  register file write data (registered)
sb_err  out  1  sticky scoreboard protocol error

Behaviour:
- Reset (rst=1 at an edge): wr_enable=0, rd_addr=0, rd=0, busy_mask=0, rr pointer=0, sb_err=0.
- Reset mid-operation: an in-flight write is dropped and its wr_enable is cleared.
- req_ready is forced to 0 while rst=1.
- Arbitration (combinational):
  - Scan requesters ptr, ptr+1, … mod NREQ; the first with req_valid gets req_ready.
  - At most one req_ready is high.
  - req_ready is never high without req_valid.
- Pointer update: after a grant to requester g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0… and no requester waits more than NREQ-1 grants.
- Write-port register (1-cycle latency):
  - On the grant edge: wr_enable <= (granted addr != 0); rd_addr <= granted addr; rd <= granted data.
  - With no grant: wr_enable <= 0; rd_addr and rd hold their values.
  - Writes to address 0 are consumed (ready=1) but never drive wr_enable.
- Scoreboard, evaluated per edge:
  - Set: rsv_valid && rsv_addr!=0 sets busy[rsv_addr].
  - Clear: wr_enable && rd_addr!=0 clears busy[rd_addr]. The clear lands on the same edge the register file commits the data.
  - Set and clear of the same address on one edge: set wins (a new producer is outstanding).
  - busy[0] is constant 0.
- chk_busy (combinational from current busy_mask, no same-cycle bypass) = busy[chk_rs1_addr] | busy[chk_rs2_addr] | busy[chk_rd_addr]. Address 0 contributes 0.
- sb_err sets and stays set until reset on either of:
  - a grant whose address is nonzero and not busy, with no same-edge reservation of that address (unreserved writeback);
  - rsv_valid on a nonzero address that is already busy with no same-edge clear (WAW reservation).
  - The offending operation still executes: the write happens, or busy stays 1.
- Requesters must hold req_valid, address and data stable until ready. The arbiter does not check this.

Test Plan:
- Reset: assert rst with all inputs active -> next cycle wr_enable=0, rd_addr=0, rd=0, busy_mask=0, sb_err=0, req_ready=0 while rst high.
- Single write: reserve x5; then req0 valid addr 5 data 0xDEADBEEF -> req_ready=001 that cycle; next cycle wr_enable=1, rd_addr=5, rd=0xDEADBEEF; busy[5] 1 through that cycle, 0 after; sb_err=0.
- Round-robin: all three valid for 6 cycles, distinct addrs reserved -> grant order 0,1,2,0,1,2; no cycle with two grants.
- Hazard check: x7 busy, chk_rs2_addr=7 -> chk_busy=1; after x7 commits -> 0. chk_rs1_addr=0 never raises chk_busy.
- Simultaneous set/clear: rsv x9 on the same edge wr_enable commits x9 -> busy[9] stays 1, sb_err=0.
- Errors: writeback to unreserved x3 -> x3 written, sb_err=1. Writeback to x0 -> ready=1, wr_enable stays 0. Re-reserving busy x4 -> sb_err=1. rst clears sb_err.
